// File: rtl/mc_control_unit.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait-state timeout.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap (sticky illegal_op) instead of running as a NOP.
module mc_control_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Opcode,
  input  logic       zero_flag,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_rd,
  output logic       dmem_wr,
  output logic [1:0] ALUOp,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       bus_err,
  output logic       illegal_op,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  function automatic logic f_ld(input logic [3:0] o);
    return o == 4'b0000;
  endfunction

  function automatic logic f_st(input logic [3:0] o);
    return o == 4'b0001;
  endfunction

  function automatic logic f_rtype(input logic [3:0] o);
    return (o >= 4'd2) && (o <= 4'd9);
  endfunction

  function automatic logic f_beq(input logic [3:0] o);
    return o == 4'b1011;
  endfunction

  function automatic logic f_bne(input logic [3:0] o);
    return o == 4'b1100;
  endfunction

  function automatic logic f_jmp(input logic [3:0] o);
    return o == 4'b1101;
  endfunction

  function automatic logic f_illegal(input logic [3:0] o);
    return (o == 4'b1010) || (o == 4'b1110) || (o == 4'b1111);
  endfunction

`ifdef ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 4'b0000;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
      ill_q     <= ill_d;
`endif
    end
  end

  // The wait counter only advances while a request stays pending in the same
  // state, so it is implicitly zero on entry to FETCH/MEM and after any ack.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = '0;
    bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    ill_d     = ill_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (cnt_q == TMO) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        op_d = Opcode;
        if (f_jmp(Opcode)) begin
          state_d = S_FETCH;
        end else if (f_illegal(Opcode)) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
          ill_d   = 1'b1;
`else
          state_d = S_EXEC;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (f_ld(op_q) || f_st(op_q)) state_d = S_MEM;
        else if (f_rtype(op_q))       state_d = S_WB;
        else                          state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = f_ld(op_q) ? S_WB : S_FETCH;
        end else if (cnt_q == TMO) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is asserted, including the sticky flags.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    ALUOp      = 2'b00;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (f_jmp(Opcode)) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
        end
        S_EXEC: begin
          if (f_ld(op_q) || f_st(op_q)) begin
            ALUOp   = 2'b10;
            alu_src = 1'b1;
          end else if (f_beq(op_q)) begin
            ALUOp    = 2'b01;
            pc_write = zero_flag;
            pc_src   = 2'b01;
          end else if (f_bne(op_q)) begin
            ALUOp    = 2'b01;
            pc_write = !zero_flag;
            pc_src   = 2'b01;
          end
        end
        S_MEM: begin
          ALUOp   = 2'b10;
          alu_src = 1'b1;
          if (f_ld(op_q)) dmem_rd = 1'b1;
          else            dmem_wr = 1'b1;
        end
        S_WB: begin
          reg_write = 1'b1;
          if (f_ld(op_q)) begin
            mem_to_reg = 1'b1;
            ALUOp      = 2'b10;
          end else begin
            reg_dst = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_err   = rst_n & bus_err_q;
  assign state_dbg = rst_n ? state_q : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = rst_n & ill_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction stream checked cycle-by-cycle against a per-instruction trace model.
module tb_mc_control_unit;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Opcode;
  logic       zero_flag, imem_ack, dmem_ack;
  logic       imem_req, ir_load, dmem_rd, dmem_wr;
  logic [1:0] ALUOp, pc_src;
  logic       alu_src, reg_dst, reg_write, mem_to_reg, pc_write;
  logic       bus_err, illegal_op;
  logic [2:0] state_dbg;

  int  n_vec = 0;
  int  n_err = 0;
  logic err_exp = 1'b0;
  logic ill_exp = 1'b0;

  mc_control_unit #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .zero_flag(zero_flag),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .ir_load(ir_load), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .ALUOp(ALUOp),
    .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
    .bus_err(bus_err), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {state_dbg, imem_req, ir_load, dmem_rd, dmem_wr, ALUOp, alu_src,
                reg_dst, reg_write, mem_to_reg, pc_write, pc_src, bus_err, illegal_op};

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (st,ireq,irl,rd,wr,aluop,src,dst,rw,m2r,pcw,pcs,err,ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [2:0] st, input logic ir, input logic il,
                                     input logic rd, input logic wr, input logic [1:0] ao,
                                     input logic src, input logic dst, input logic rw,
                                     input logic m2r, input logic pcw, input logic [1:0] pcs);
    return {st, ir, il, rd, wr, ao, src, dst, rw, m2r, pcw, pcs, err_exp, ill_exp};
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle's inputs just after the rising edge, check on the falling edge.
  task automatic cyc(input logic ia, input logic da, input logic zf, input logic [3:0] opc,
                     input logic [17:0] exp, input string tag);
    imem_ack  = ia;
    dmem_ack  = da;
    zero_flag = zf;
    Opcode    = opc;
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(rbit(), rbit(), rbit(), rnd4(), 18'h0, "reset_outputs");
    rst_n   = 1'b1;
    err_exp = 1'b0;
    ill_exp = 1'b0;
  endtask

  task automatic hold_check(input logic [2:0] st, input string tag);
    for (int i = 0; i < 3; i++)
      cyc(rbit(), rbit(), rbit(), rnd4(),
          mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), tag);
  endtask

  // One instruction: iw/dw are memory wait cycles before ack (>TMO means never acked).
  task automatic run_instr(input logic [3:0] op, input logic zf, input int iw, input int dw,
                           input bit rst_mem);
    logic is_ld, is_st, is_r, is_beq, is_bne, is_jmp, is_ill, taken;
    logic [1:0] ao;
    is_ld  = (op == 4'd0);
    is_st  = (op == 4'd1);
    is_r   = (op >= 4'd2) && (op <= 4'd9);
    is_beq = (op == 4'd11);
    is_bne = (op == 4'd12);
    is_jmp = (op == 4'd13);
    is_ill = !(is_ld || is_st || is_r || is_beq || is_bne || is_jmp);
    ao     = (is_ld || is_st) ? 2'b10 : ((is_beq || is_bne) ? 2'b01 : 2'b00);
    taken  = (is_beq && zf) || (is_bne && !zf);

    for (int k = 0; k <= iw && k <= TMO; k++)
      cyc(k == iw, 1'b0, rbit(), rnd4(),
          mk(3'd0, 1'b1, k == iw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, k == iw, 2'b00),
          (k == iw) ? "fetch_ack" : "fetch_wait");
    if (iw > TMO) begin
      err_exp = 1'b1;
      hold_check(3'd5, "imem_timeout_err");
      do_reset();
      return;
    end

    cyc(1'b0, 1'b0, rbit(), op,
        mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, is_jmp,
           is_jmp ? 2'b10 : 2'b00), "decode");
    if (is_jmp) return;
`ifdef ILLEGAL_TRAP_EN
    if (is_ill) begin
      ill_exp = 1'b1;
      hold_check(3'd6, "trap_hold");
      do_reset();
      return;
    end
`endif

    cyc(1'b0, 1'b0, zf, rnd4(),
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ao, is_ld || is_st, 1'b0, 1'b0, 1'b0, taken,
           (is_beq || is_bne) ? 2'b01 : 2'b00), "exec");
    if (is_beq || is_bne || is_ill) return;

    if (is_r) begin
      cyc(1'b0, 1'b0, rbit(), rnd4(),
          mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00), "wb_r");
      return;
    end

    for (int k = 0; k <= dw && k <= TMO; k++) begin
      if (rst_mem && k == 1) begin
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, rbit(), rnd4(), 18'h0, "reset_in_mem");
        rst_n = 1'b1;
        return;
      end
      cyc(1'b0, k == dw, rbit(), rnd4(),
          mk(3'd3, 1'b0, 1'b0, is_ld, is_st, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00),
          (k == dw) ? "mem_ack" : "mem_wait");
    end
    if (dw > TMO) begin
      err_exp = 1'b1;
      hold_check(3'd5, "dmem_timeout_err");
      do_reset();
      return;
    end
    if (is_ld)
      cyc(1'b0, 1'b0, rbit(), rnd4(),
          mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00), "wb_ld");
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(0, 3);
    if (r < 92) return TMO;
    if (r < 96) return TMO + 1;
    return TMO - 1;
  endfunction

  initial begin
    rst_n = 1'b0; Opcode = 4'd0; zero_flag = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(4'b0010, 1'b0, 0, 0, 1'b0);    // ADD, zero-wait
    run_instr(4'b0000, 1'b0, 0, 3, 1'b0);    // LD, 3 wait states
    run_instr(4'b1011, 1'b1, 0, 0, 1'b0);    // BEQ taken
    run_instr(4'b1100, 1'b1, 0, 0, 1'b0);    // BNE not taken
    run_instr(4'b1101, 1'b0, 1, 0, 1'b0);    // JMP
    run_instr(4'b0011, 1'b0, TMO, 0, 1'b0);  // ack exactly at timeout wins
    run_instr(4'b0010, 1'b0, TMO + 1, 0, 1'b0);
    run_instr(4'b1110, 1'b0, 0, 0, 1'b0);    // illegal
    run_instr(4'b0001, 1'b0, 0, 3, 1'b1);    // ST, reset during MEM
    run_instr(4'b0001, 1'b0, 0, TMO, 1'b0);
    run_instr(4'b0000, 1'b0, 0, TMO + 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      int dw;
      bit rm;
      op = rnd4();
      dw = pick_wait();
      rm = ($urandom_range(0, 19) == 0);
      if (rm && dw < 2) dw = 2;
      run_instr(op, rbit(), pick_wait(), dw, rm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
